// File: rtl/fifo_word_splitter_pkg.sv
// Shared definitions for the word splitter: default symbol width, FSM
// state encoding and a saturating counter helper.
package fifo_word_splitter_pkg;

    // Default symbol width; matches the data width of the downstream symbol FIFO.
    localparam int DEF_SYM_W = 2;

    // Splitter FSM states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_word_splitter.sv
// Word-to-symbol splitter feeding a symbol FIFO. Accepts one WORD_W-bit
// word over valid/ready and pushes its WORD_W/SYM_W symbols one per cycle,
// stalling while the FIFO reports full. The next word can be accepted on
// the cycle that pushes the last symbol, so back-to-back words run without
// a bubble.
module fifo_word_splitter
    import fifo_word_splitter_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int SYM_W     = DEF_SYM_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,        // asynchronous, active low
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_word,
    output logic              in_ready,
    input  logic              fifo_full,
    output logic              fifo_push,
    output logic [SYM_W-1:0]  fifo_in,
    output logic              busy,
    output logic [15:0]       word_count,
    output logic [15:0]       stall_count
);

    localparam int                N        = WORD_W / SYM_W;
    localparam int                IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

    // A word must split into a whole number of symbols.
    generate
        if ((WORD_W % SYM_W) != 0) begin : g_bad_width
            $error("fifo_word_splitter: WORD_W must be a multiple of SYM_W");
        end
    endgenerate

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_W-1:0]   r_shift;
    logic [IDX_W-1:0]    r_idx;
    logic [15:0]         r_word_count;
    logic [15:0]         r_stall_count;

    logic                w_send;
    logic                w_last;
    logic                w_push;
    logic                w_ready;
    logic                w_accept;
    logic                w_word_done;
    logic                w_stall;
    logic [SYM_W-1:0]    w_sym;

    // Handshake and push decode. The push is gated by fifo_full here so the
    // FIFO never sees a write while full.
    always_comb begin
        w_send      = (r_state == ST_SEND);
        w_last      = (r_idx == LAST_IDX);
        w_push      = w_send & ~fifo_full;
        w_stall     = w_send & fifo_full;
        w_word_done = w_push & w_last;
        w_ready     = (r_state == ST_IDLE) | w_word_done;
        w_accept    = in_valid & w_ready;
        if (MSB_FIRST) begin
            w_sym = r_shift[WORD_W-1 -: SYM_W];
        end else begin
            w_sym = r_shift[SYM_W-1:0];
        end
    end

    // Next-state logic: IDLE waits for a word, SEND stays while symbols remain
    // or while a follow-on word is taken on the last push.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = ST_SEND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (w_word_done) begin
                    if (in_valid) begin
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shift register and symbol index: load on accept, advance on a non-final
    // push, hold otherwise (including every stalled cycle).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_shift <= in_word;
            r_idx   <= '0;
        end else if (w_push && !w_last) begin
            if (MSB_FIRST) begin
                r_shift <= r_shift << SYM_W;
            end else begin
                r_shift <= r_shift >> SYM_W;
            end
            r_idx <= r_idx + IDX_W'(1);
        end else begin
            r_shift <= r_shift;
            r_idx   <= r_idx;
        end
    end

    // Debug counters: completed words (wrapping) and stalled SEND cycles
    // (saturating).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word_count  <= 16'd0;
            r_stall_count <= 16'd0;
        end else begin
            if (w_word_done) begin
                r_word_count <= r_word_count + 16'd1;
            end else begin
                r_word_count <= r_word_count;
            end
            if (w_stall) begin
                r_stall_count <= sat_inc16(r_stall_count);
            end else begin
                r_stall_count <= r_stall_count;
            end
        end
    end

    assign in_ready    = w_ready;
    assign fifo_push   = w_push;
    assign fifo_in     = w_sym;
    assign busy        = w_send;
    assign word_count  = r_word_count;
    assign stall_count = r_stall_count;

endmodule
